if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, instruction queue depth; power of two, at least 2.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, value driven on id_instr when the queue is empty.
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_in  in  32  current fetch PC from the PC register.
REQ-006 SHALL have port pc_hold  out  1  PC register must not advance this cycle.
REQ-007 SHALL have port flush  in  1  redirect resolved; PC register loads the target this cycle.
REQ-008 SHALL have port imem_req  out  1  instruction memory read strobe.
REQ-009 SHALL have port imem_addr  out  32  word-aligned read address.
REQ-010 SHALL have port imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
REQ-011 SHALL have port id_valid  out  1  queue head holds a valid instruction.
REQ-012 SHALL have port id_ready  in  1  decode accepts the head this cycle.
REQ-013 SHALL have port id_pc  out  32  PC of the head entry.
REQ-014 SHALL have port id_instr  out  32  instruction of the head entry.
REQ-015 SHALL have port id_misalign  out  1  head entry fetched from a PC with pc[1:0] != 0.

Function
REQ-016 SHALL define pop = id_valid & id_ready and issue = !reset & !flush & (count + inflight - pop < QDEPTH).
REQ-017 SHALL drive imem_req = issue and imem_addr = {pc_in[31:2], 2'b00} combinationally.
REQ-018 SHALL drive pc_hold = !issue & !flush & !reset; a flush never holds the PC register.
REQ-019 SHALL register inflight <= issue, plus req_pc <= pc_in and req_mis <= (pc_in[1:0] != 0) when issue.
REQ-020 SHALL push {req_pc, imem_rdata, req_mis} into the queue at the edge ending any cycle with inflight=1 and flush=0.
REQ-021 SHALL remove the head at the edge ending any cycle with pop=1.
REQ-022 SHALL keep count unchanged on simultaneous push and pop, with no loss or duplication, including when count=QDEPTH-1 or count=1.
REQ-023 SHALL wrap read/write pointers modulo QDEPTH; push never occurs while full, and pop never occurs while empty.
REQ-024 SHALL drive id_valid = (count != 0); id_pc/id_instr/id_misalign come from head; when empty, id_pc=0, id_instr=NOP_INSTR, id_misalign=0.
REQ-025 SHALL give latency pc_in issued in cycle N -> id_valid with that pc in cycle N+2.
REQ-026 SHALL sustain one instruction per cycle while id_ready=1 and flush=0.
REQ-027 SHALL, on flush, clear count, pointers and inflight at that edge, discard the response arriving in flush cycle, and issue nothing that cycle.
REQ-028 SHALL ignore id_ready in the cycle of a flush for queue state (flush wins over pop and push).
REQ-029 SHALL hold head outputs stable while id_valid=1 and id_ready=0.

Reset
REQ-030 SHALL, during reset, force imem_req=0, pc_hold=0, and clear count, pointers, inflight, req_pc, and req_mis.
REQ-031 SHALL output id_valid=0, id_pc=0, id_instr=NOP_INSTR, and id_misalign=0 in the cycle after reset is sampled.
REQ-032 SHALL, on reset asserted mid-operation, discard any in-flight response with no stale push afterwards.

Verification
REQ-033 SHALL cover streaming: release reset, pc_in 0,4,8,... advancing when pc_hold=0, imem_rdata=addr+0x13, id_ready=1 -> id_valid first at cycle 2, then every cycle, id_pc 0,4,8 with matching instr.
REQ-034 SHALL cover backpressure: id_ready=0 from cycle 0 -> two entries (pc 0,4) captured, then pc_hold=1, imem_req=0; raise id_ready -> pc 0,4,8 delivered in order, no gaps or duplicates.
REQ-035 SHALL cover flush with a full queue and a request in flight: flush at cycle F, pc_in=0x100 at F+1 -> id_valid=0 at F+1, discarded response never seen, id_pc=0x100 at F+3.
REQ-036 SHALL cover a misaligned PC: pc_in=0x102 -> imem_addr=0x100, delivered entry has id_pc=0x102 and id_misalign=1.
REQ-037 SHALL cover reset mid-stream: queue full and request in flight, reset for one cycle -> id_valid=0 next cycle, and no entry appears until a new issue completes.
REQ-038 SHALL cover simultaneous push/pop: count=1, inflight=1, id_ready=1 -> count stays 1, and the next head is the newly pushed entry.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: issues one imem read per cycle while the queue has room,
// captures responses one cycle later, and presents the oldest entry to decode.
module if_fetch_unit #(
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_misalign
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(QDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  entry_t          q [QDEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [31:0]     req_pc;
  logic            req_mis;
  logic            pop, push, issue;
  logic [CW:0]     occ;

  assign pop  = id_valid & id_ready;
  assign push = inflight & ~flush & ~reset;

  // Occupancy after this cycle: entries held plus the response still owed, minus what decode takes.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = ~reset & ~flush & (occ < DEPTH_V);

  assign imem_req  = issue;
  assign imem_addr = {pc_in[31:2], 2'b00};
  assign pc_hold   = ~issue & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      if (reset) begin
        req_pc  <= '0;
        req_mis <= 1'b0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc  <= pc_in;
        req_mis <= (pc_in[1:0] != 2'b00);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{pc: req_pc, instr: imem_rdata, mis: req_mis};
  end

  assign head        = q[rd_ptr];
  assign id_valid    = (count != '0);
  assign id_pc       = id_valid ? head.pc    : 32'h0;
  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_misalign = id_valid & head.mis;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a queue-level model predicts requests and delivered entries.
module tb_if_fetch_unit;
  localparam int          QD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, id_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_hold, imem_req, id_valid, id_misalign;
  logic [31:0] imem_addr, id_pc, id_instr;

  always #5 clk = ~clk;

  if_fetch_unit #(.QDEPTH(QD), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_hold(pc_hold), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_misalign(id_misalign)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  int   n_vec = 0, n_err = 0;
  ent_t exp_q[$];
  bit   m_inflight = 1'b0;
  ent_t m_pend;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory: answers a strobed read during the following cycle.
  initial begin
    logic        r;
    logic [31:0] a;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      r = imem_req;
      a = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = r ? mem_fn(a) : $urandom;
    end
  end

  // Monitor: compares the presented head with the oldest expected entry.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("id_pc", id_pc, exp_q[0].pc);
        chk("id_instr", id_instr, exp_q[0].instr);
        chk("id_misalign", 32'(id_misalign), 32'(exp_q[0].mis));
        if (id_ready) void'(exp_q.pop_front());
      end else begin
        chk("empty_pc", id_pc, 32'h0);
        chk("empty_instr", id_instr, NOP);
        chk("empty_mis", 32'(id_misalign), 32'h0);
      end
    end
  end

  // Reference model: a bounded queue plus one outstanding response.
  initial begin
    bit exp_issue;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      exp_issue = !reset && !flush && (exp_q.size() + int'(m_inflight) < QD);
      chk("imem_req", 32'(imem_req), 32'(exp_issue));
      chk("pc_hold", 32'(pc_hold), 32'(!exp_issue && !flush && !reset));
      if (exp_issue) chk("imem_addr", imem_addr, {pc_in[31:2], 2'b00});
      if (reset || flush) begin
        exp_q.delete();
        m_inflight = 1'b0;
      end else begin
        if (m_inflight) exp_q.push_back(m_pend);
        m_inflight = exp_issue;
        if (exp_issue) m_pend = '{pc: pc_in, instr: mem_fn({pc_in[31:2], 2'b00}),
                                  mis: (pc_in[1:0] != 2'b00)};
      end
    end
  end

  // One cycle of stimulus; pc_in behaves like the PC register (flush target, hold, or +4).
  task automatic step(input bit rdy, input bit fl, input bit rs, input logic [31:0] tgt);
    bit hold;
    id_ready = rdy;
    flush    = fl;
    reset    = rs;
    @(negedge clk);
    hold = pc_hold;
    @(posedge clk);
    #1;
    if (rs)         pc_in = 32'h0;
    else if (fl)    pc_in = tgt;
    else if (!hold) pc_in = pc_in + 32'd4;
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0; pc_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0);                 // streaming
    step(1'b0, 1'b1, 1'b0, 32'h0);                             // restart at 0
    repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0);                  // backpressure
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);                  // fill, then flush
    step(1'b1, 1'b1, 1'b0, 32'h100);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h102);                           // misaligned target
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);                             // count=1 with inflight, then pop+push
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);                  // reset mid-stream
    step(1'b1, 1'b0, 1'b1, 32'h0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (500) begin
      t = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 49) == 0, t);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
